mmem_rd_ctrl: RTL

//  Read-burst initiator for the main memory block. Accepts a descriptor (base, length, stride) and

---
 rtl/mmem_rd_ctrl_if.sv | 49 ++++
 rtl/mmem_rd_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mmem_rd_ctrl_if.sv
// Bus bundle for the main-memory read-burst initiator: descriptor, memory read port,
// streamed output, and status. Widths must match the mmem_rd_ctrl instance parameters.
interface mmem_rd_ctrl_if #(
    parameter int unsigned ADDR_WDT = 16,
    parameter int unsigned DATA_WDT = 64,
    parameter int unsigned LEN_WDT  = 16
);
    // Descriptor from the layer sequencer
    logic                cmd_val;
    logic                cmd_rdy;
    logic [ADDR_WDT-1:0] cmd_base_addr;
    logic [LEN_WDT-1:0]  cmd_len;
    logic [ADDR_WDT-1:0] cmd_stride;

    // Main memory read port
    logic                mmem_rd_en;
    logic [ADDR_WDT-1:0] mmem_rd_addr;
    logic [DATA_WDT-1:0] mmem_data_out;

    // Streamed output
    logic [DATA_WDT-1:0] out_word;
    logic                out_val;
    logic                out_rdy;

    // Status
    logic                busy;
    logic                done;
    logic [31:0]         stat_stall_cnt;

    // Controller side
    modport slave (
        input  cmd_val, cmd_base_addr, cmd_len, cmd_stride,
        input  mmem_data_out,
        input  out_rdy,
        output cmd_rdy, mmem_rd_en, mmem_rd_addr,
        output out_word, out_val,
        output busy, done, stat_stall_cnt
    );

    // Environment side (sequencer + memory + consumer)
    modport master (
        output cmd_val, cmd_base_addr, cmd_len, cmd_stride,
        output mmem_data_out,
        output out_rdy,
        input  cmd_rdy, mmem_rd_en, mmem_rd_addr,
        input  out_word, out_val,
        input  busy, done, stat_stall_cnt
    );
endinterface

// File: rtl/mmem_rd_ctrl.sv
// Read-burst initiator for main memory. Takes a (base, len, stride) descriptor, issues
// single-word reads against a fixed-latency memory, buffers returns in a credit-guarded
// first-word-fall-through FIFO and streams them out with valid/ready.
// Optional feature macro: MMEM_RD_CTRL_STAT_EN enables the saturating credit-stall counter
// on stat_stall_cnt; without it the output is tied to zero.
module mmem_rd_ctrl #(
    parameter int unsigned ADDR_WDT   = 16,
    parameter int unsigned DATA_WDT   = 64,
    parameter int unsigned LEN_WDT    = 16,
    parameter int unsigned RD_LAT     = 4,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    mmem_rd_ctrl_if.slave bus
);
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned SUM_W = CNT_W + 1;

    // Parameter sanity: the credit scheme needs room for a full latency pipe plus one
    if (RD_LAT < 1) begin : g_bad_lat
        $error("mmem_rd_ctrl: RD_LAT must be >= 1");
    end
    if (FIFO_DEPTH < RD_LAT + 1) begin : g_bad_depth
        $error("mmem_rd_ctrl: FIFO_DEPTH must be >= RD_LAT+1");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Control state
    state_e              state_q, state_d;
    logic [LEN_WDT-1:0]  rem_q, rem_d;
    logic [ADDR_WDT-1:0] stride_q, stride_d;
    logic [ADDR_WDT-1:0] addr_q, addr_d;
    logic                rd_en_q, rd_en_d;

    // Latency tracking
    logic [RD_LAT-1:0]   pipe_q, pipe_d;
    logic [CNT_W-1:0]    infl_q, infl_d;

    // Return FIFO
    logic [DATA_WDT-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                val_q, val_d;
    logic [DATA_WDT-1:0] word_q, word_d;

    // Registered status outputs
    logic                cmd_rdy_q, cmd_rdy_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    // Per-cycle events
    logic                accept_c;
    logic                push_c;
    logic                pop_c;
    logic                issue_c;
    logic [SUM_W-1:0]    credit_sum_c;
    logic                credit_ok_c;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Handshake events and credit: a pop in this cycle frees its slot before the issue decision
    always_comb begin
        accept_c     = bus.cmd_val & cmd_rdy_q;
        push_c       = pipe_q[RD_LAT-1];
        pop_c        = val_q & bus.out_rdy;
        credit_sum_c = SUM_W'(infl_q) + SUM_W'(cnt_q) - SUM_W'(pop_c);
        credit_ok_c  = (credit_sum_c < SUM_W'(FIFO_DEPTH));
    end

    // FSM next state, descriptor capture and request generation
    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        stride_d = stride_q;
        addr_d   = addr_q;
        issue_c  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                // FIFO and pipe are always empty in IDLE, so the first read needs no credit check
                if (accept_c) begin
                    stride_d = bus.cmd_stride;
                    if (bus.cmd_len != '0) begin
                        state_d = ST_ISSUE;
                        issue_c = 1'b1;
                        addr_d  = bus.cmd_base_addr;
                        rem_d   = bus.cmd_len - LEN_WDT'(1);
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_ISSUE: begin
                if (rem_q == '0) begin
                    state_d = ST_DRAIN;
                end else if (credit_ok_c) begin
                    issue_c = 1'b1;
                    addr_d  = addr_q + stride_q;
                    rem_d   = rem_q - LEN_WDT'(1);
                end
            end
            ST_DRAIN: begin
                if ((infl_q == '0) && (cnt_q == '0)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Latency pipe, in-flight count, FIFO pointers and registered FWFT head
    always_comb begin
        rd_en_d  = issue_c;
        pipe_d   = pipe_q;
        infl_d   = infl_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        word_d   = word_q;

        pipe_d[0] = rd_en_q;
        for (int i = 1; i < int'(RD_LAT); i++) begin
            pipe_d[i] = pipe_q[i-1];
        end

        // in_flight covers the request on the bus now plus everything in the pipe
        infl_d = infl_q + CNT_W'(issue_c) - CNT_W'(push_c);

        if (push_c) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop_c) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        cnt_d = cnt_q + CNT_W'(push_c) - CNT_W'(pop_c);
        val_d = (cnt_d != '0);

        // Head bypasses the array when the pushed word lands in an otherwise empty FIFO
        if (push_c && (cnt_q == CNT_W'(pop_c))) begin
            word_d = bus.mmem_data_out;
        end else if (cnt_d != '0) begin
            word_d = mem_q[rd_ptr_d];
        end

        cmd_rdy_d = (state_d == ST_IDLE);
        busy_d    = (state_d != ST_IDLE);
        done_d    = (state_d == ST_DONE);
    end

    // Control and datapath registers; reset drops everything including in-flight returns
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            rem_q     <= '0;
            stride_q  <= '0;
            addr_q    <= '0;
            rd_en_q   <= 1'b0;
            pipe_q    <= '0;
            infl_q    <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            val_q     <= 1'b0;
            word_q    <= '0;
            cmd_rdy_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            stride_q  <= stride_d;
            addr_q    <= addr_d;
            rd_en_q   <= rd_en_d;
            pipe_q    <= pipe_d;
            infl_q    <= infl_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            val_q     <= val_d;
            word_q    <= word_d;
            cmd_rdy_q <= cmd_rdy_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // FIFO storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= bus.mmem_data_out;
        end
    end

`ifdef MMEM_RD_CTRL_STAT_EN
    logic [31:0] stall_q, stall_d;
    logic        stall_c;

    // Count ISSUE cycles where the credit rule holds back a pending request
    always_comb begin
        stall_c = (state_q == ST_ISSUE) && (rem_q != '0) && !credit_ok_c;
        stall_d = stall_q;
        if (accept_c) begin
            stall_d = '0;
        end else if (stall_c && (stall_q != '1)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    // Stall counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign bus.stat_stall_cnt = stall_q;
`else
    assign bus.stat_stall_cnt = 32'd0;
`endif

    // Credit invariants: the FIFO can never be pushed while full
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(push_c && (cnt_q == CNT_W'(FIFO_DEPTH))))
                else $error("mmem_rd_ctrl: push into full FIFO");
            assert ((SUM_W'(infl_q) + SUM_W'(cnt_q)) <= SUM_W'(FIFO_DEPTH))
                else $error("mmem_rd_ctrl: credit overrun");
        end
    end

    assign bus.cmd_rdy      = cmd_rdy_q;
    assign bus.mmem_rd_en   = rd_en_q;
    assign bus.mmem_rd_addr = addr_q;
    assign bus.out_word     = word_q;
    assign bus.out_val      = val_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
endmodule
